if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues word fetches on the instruction bus with
//  up to MAX_OUTSTANDING requests in flight, and buffers in-order responses in a small
//  prefetch FIFO. Feeds the IF/ID pipeline register.
//  Honours ctrl stall vector and jump flush; discards stale in-flight responses after a jump.
// PARAMETERS
//  ADDR_WIDTH       `ADDR_WIDTH (32)  instruction address width
//  DATA_WIDTH       `DATA_WIDTH (32)  instruction width
//  RESET_PC         32'h0000_0000    PC after reset
//  FIFO_DEPTH       2                prefetch buffer entries (power of 2, >=2)
//  MAX_OUTSTANDING  2                max granted-but-unanswered requests (<=FIFO_DEPTH)
// PORTS
//  clk_i          in   1           clock, rising edge
//  rst_n_i        in   1           asynchronous active-low reset
//  stall_i        in   6           ctrl stall vector; [1]==`STOP holds the head entry
//  flush_jump_i   in   1           redirect this cycle
//  jump_addr_i    in   ADDR_WIDTH  redirect target
//  ibus_req_o     out  1           fetch request
//  ibus_addr_o    out  ADDR_WIDTH  fetch address (word aligned)
//  ibus_gnt_i     in   1           request accepted this cycle
//  ibus_rvalid_i  in   1           response data valid (in request order)
//  ibus_rdata_i   in   DATA_WIDTH  response instruction word
//  inst_addr_o    out  ADDR_WIDTH  to IF/ID: instruction address
//  inst_o         out  DATA_WIDTH  to IF/ID: instruction
//  inst_valid_o   out  1           head entry valid (FIFO non-empty)
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, FIFO empty, outstanding=0, discard=0;
//   ibus_req_o=0, inst_valid_o=0, inst_o=`NOP, inst_addr_o=0.
//  Issue: ibus_req_o = !flush_jump_i && outstanding<MAX_OUTSTANDING
//   && (fifo_count + outstanding - discard) < FIFO_DEPTH; ibus_addr_o = pc.
//   req/addr stay stable until gnt except when flush_jump_i drops req (allowed, no gnt).
//   On req&&gnt: pc<=pc+4 (wraps modulo 2^ADDR_WIDTH), outstanding++, pc pushed to addr queue.
//  Response: rvalid pops addr queue, outstanding--. If discard>0: drop, discard--;
//   else push {addr,rdata} to prefetch FIFO. rvalid with outstanding==0 is a bus error:
//   ignored (assertion in sim).
//  Output: combinational from FIFO head; empty -> inst_o=`NOP, inst_addr_o=0, valid=0.
//   Pop when valid && stall_i[1]==`NOSTOP && !flush_jump_i. Push+pop same cycle allowed
//   (count unchanged). Zero-latency bypass from rvalid to output is NOT provided:
//   rdata reaches inst_o the cycle after rvalid.
//  Flush (highest priority after reset): pc<={jump_addr_i[AW-1:2],2'b00}; FIFO cleared;
//   discard<=outstanding - rvalid_i (response in flush cycle is dropped); no gnt possible
//   in flush cycle. New requests to target from next cycle, even while discard>0.
//  Stall: stall_i[0]==`STOP freezes issue (req=0) but responses still land in FIFO.
//  Full: FIFO full and no pop -> no issue; credit rule guarantees no response overflow.
//  Back-to-back flushes: each recomputes discard from current outstanding; last target wins.
// STRUCTURE
//  defines.v: ADDR_WIDTH, DATA_WIDTH, `NOP, `STOP/`NOSTOP, RESET_PC.
//  Sub-module if_fifo (sync FIFO, WIDTH/DEPTH params, push/pop/clear, count, async
//   active-low reset), instantiated twice: address queue (depth MAX_OUTSTANDING) and
//   prefetch buffer (width ADDR+DATA, depth FIFO_DEPTH). Top holds pc, outstanding, discard.
// TESTING
//  1 Reset release, gnt=1, rvalid 1 cycle later, no stall -> addrs 0,4,8 issued on
//    consecutive cycles; IF/ID sees inst_addr 0,4,8 with matching rdata.
//  2 stall_i[1]=`STOP for 5 cycles with gnt/rvalid always 1 -> FIFO fills to 2, req drops,
//    head (addr 0x0) held stable; release -> 0x4, 0x8 drain in order, no loss/duplicate.
//  3 Two requests outstanding (0x10,0x14), flush to 0x200 -> both responses dropped,
//    next issued addr 0x200, first delivered inst_addr 0x200.
//  4 Flush coincident with rvalid of 0x10 and one more outstanding -> discard=1; only
//    responses for 0x200+ delivered.
//  5 jump_addr_i=0x203 -> fetch at 0x200; pc=0xFFFF_FFFC fetch -> next addr 0x0 (wrap).
//  6 Assert rst_n_i mid-burst with FIFO full -> outputs return to reset values immediately
//    (async); after release first fetch at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package if_fetch_pkg;

  localparam int          IF_ADDR_WIDTH = 32;
  localparam int          IF_DATA_WIDTH = 32;
  localparam logic [31:0] IF_RESET_PC   = 32'h0000_0000;

  // addi x0, x0, 0 -- presented to IF/ID whenever no instruction is available.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Pipeline stall vector encoding and the bits this stage looks at.
  localparam logic STOP     = 1'b1;
  localparam logic NOSTOP   = 1'b0;
  localparam int   STALL_W  = 6;
  localparam int   STALL_IF = 0;  // freezes new fetch requests
  localparam int   STALL_ID = 1;  // holds the entry presented to IF/ID

  // Bits needed to hold a count in the range 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n storage slots.
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO with clear, used for the fetch address queue and prefetch buffer.
// Latency: data pushed in cycle N is visible at head_dat in cycle N+1 (no bypass).
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
//
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   clr             synchronous empty (wins over push/pop)
//   push, push_dat  write request and data
//   pop             read request (ignored when empty)
//   head_dat        oldest entry (stale storage when empty)
//   count           number of valid entries
//   empty, full     status flags
module if_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW   = ptr_width(DEPTH),
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so the depth need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues pipelined word fetches, buffers in-order responses for IF/ID.
// Latency: a response reaches inst_o the cycle after ibus_rvalid_i; a request is issued the cycle the PC is valid.
// Backpressure: stall_i[1] holds the head entry; new requests are only issued when a free buffer slot is reserved.
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset (release is synchronised upstream)
//   stall_i          pipeline stall vector: [0] freezes issue, [1] holds the head entry
//   flush_jump_i     redirect this cycle, jump_addr_i is the target (low two bits ignored)
//   ibus_req_o/addr  fetch request and word-aligned address, ibus_gnt_i accepts it
//   ibus_rvalid_i    in-order response strobe with ibus_rdata_i
//   inst_addr_o/inst_o/inst_valid_o  head of the prefetch buffer towards IF/ID
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = IF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH      = IF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(IF_RESET_PC),
  parameter int                    FIFO_DEPTH      = 2,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [STALL_W-1:0]    stall_i,
  input  logic                  flush_jump_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  output logic                  ibus_req_o,
  output logic [ADDR_WIDTH-1:0] ibus_addr_o,
  input  logic                  ibus_gnt_i,
  input  logic                  ibus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] ibus_rdata_i,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic                  inst_valid_o
);

  localparam int OW = cnt_width(MAX_OUTSTANDING);
  localparam int FW = cnt_width(FIFO_DEPTH);
  localparam int SW = ((OW > FW) ? OW : FW) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] inst;
  } fetch_ent_t;

  logic [ADDR_WIDTH-1:0] pc;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         discard;

  logic                  issue_ok;
  logic                  accept;
  logic                  rsp_vld;
  logic                  rsp_keep;
  logic                  head_pop;
  logic [SW-1:0]         committed;

  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [OW-1:0]         aq_count;
  logic                  aq_empty;
  logic                  aq_full;

  fetch_ent_t            pf_push_dat;
  fetch_ent_t            pf_head;
  logic [FW-1:0]         pf_count;
  logic                  pf_empty;
  logic                  pf_full;

  // Slots already spoken for: buffered entries plus live (non-discarded) requests.
  // Issuing only while this is below the depth means every kept response has room.
  assign committed = SW'(pf_count) + SW'(outstanding) - SW'(discard);

  // Gated by reset so the bus sees no request while the block is held in reset.
  assign issue_ok = rst_n_i
                 && !flush_jump_i
                 && (stall_i[STALL_IF] == NOSTOP)
                 && (outstanding < OW'(MAX_OUTSTANDING))
                 && (committed < SW'(FIFO_DEPTH));

  assign ibus_req_o  = issue_ok;
  assign ibus_addr_o = pc;
  assign accept      = issue_ok && ibus_gnt_i;

  // A response with nothing in flight is a bus error and is ignored entirely.
  assign rsp_vld  = ibus_rvalid_i && (outstanding != '0);
  // Responses to pre-redirect requests, or arriving in a redirect cycle, are dropped.
  assign rsp_keep = rsp_vld && (discard == '0) && !flush_jump_i;

  assign inst_valid_o = !pf_empty;
  assign head_pop     = inst_valid_o && (stall_i[STALL_ID] == NOSTOP) && !flush_jump_i;
  assign inst_o       = pf_empty ? DATA_WIDTH'(INST_NOP) : pf_head.inst;
  assign inst_addr_o  = pf_empty ? '0 : pf_head.addr;

  assign pf_push_dat.addr = rsp_addr;
  assign pf_push_dat.inst = ibus_rdata_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (accept && !rsp_vld)      outstanding <= outstanding + 1'b1;
      else if (!accept && rsp_vld) outstanding <= outstanding - 1'b1;

      if (flush_jump_i) begin
        pc      <= {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
        // Everything still in flight after this cycle belongs to the old path.
        discard <= outstanding - OW'(rsp_vld);
      end else begin
        if (accept) pc <= pc + ADDR_WIDTH'(4);
        if (rsp_vld && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  // Addresses of granted requests, matched to responses in order.
  if_fetch_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_addr_q (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr      (1'b0),
    .push     (accept),
    .push_dat (pc),
    .pop      (rsp_vld),
    .head_dat (rsp_addr),
    .count    (aq_count),
    .empty    (aq_empty),
    .full     (aq_full)
  );

  // Prefetch buffer feeding IF/ID; emptied on redirect.
  if_fetch_fifo #(
    .WIDTH ($bits(fetch_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr      (flush_jump_i),
    .push     (rsp_keep),
    .push_dat (pf_push_dat),
    .pop      (head_pop),
    .head_dat (pf_head),
    .count    (pf_count),
    .empty    (pf_empty),
    .full     (pf_full)
  );

  logic unused_bits;
  assign unused_bits = ^{stall_i[STALL_W-1:2], jump_addr_i[1:0], aq_count, aq_empty, aq_full};

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    ibus_rvalid_i |-> (outstanding != '0));

  a_pf_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    rsp_keep |-> (!pf_full || head_pop));

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          DEPTH  = 2;
  localparam int          MAXO   = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [5:0]    stall_i;
  logic          flush_jump_i;
  logic [AW-1:0] jump_addr_i;
  logic          ibus_req_o;
  logic [AW-1:0] ibus_addr_o;
  logic          ibus_gnt_i;
  logic          ibus_rvalid_i;
  logic [DW-1:0] ibus_rdata_i;
  logic [AW-1:0] inst_addr_o;
  logic [DW-1:0] inst_o;
  logic          inst_valid_o;

  always #5 clk_i = ~clk_i;

  if_fetch #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .stall_i       (stall_i),
    .flush_jump_i  (flush_jump_i),
    .jump_addr_i   (jump_addr_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_addr_o   (inst_addr_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory image served by the bus: a fixed hash of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 'x;
  endfunction

  // Reference model: requests in flight (with a stale mark set by a redirect),
  // buffered instructions, and the next fetch address.
  typedef struct { logic [31:0] addr; bit stale; } fl_t;
  typedef struct { logic [31:0] addr; logic [31:0] inst; } ent_t;
  fl_t         inflight[$];
  ent_t        pf[$];
  logic [31:0] m_pc;

  // Bus responder queue and observation logs.
  logic [31:0] bus_q[$];
  logic [31:0] issued[$];
  logic [31:0] delivered[$];

  task automatic model_reset();
    inflight.delete();
    pf.delete();
    bus_q.delete();
    m_pc = RST_PC;
  endtask

  task automatic clear_logs();
    issued.delete();
    delivered.delete();
  endtask

  // One clock cycle: drive at negedge, compare just after, advance the model.
  task automatic step(input logic [5:0] st, input bit fl, input logic [31:0] ja,
                      input int pg, input int pr);
    bit          rv, e_req, acc, pop, got_r;
    int          live;
    logic [31:0] rd;
    fl_t         r;
    @(negedge clk_i);
    rv = (bus_q.size() > 0) && ($urandom_range(99) < pr);
    rd = rv ? word_at(bus_q[0]) : $urandom;
    stall_i       = st;
    flush_jump_i  = fl;
    jump_addr_i   = ja;
    ibus_gnt_i    = ($urandom_range(99) < pg);
    ibus_rvalid_i = rv;
    ibus_rdata_i  = rd;
    #1;
    live = 0;
    foreach (inflight[i]) if (!inflight[i].stale) live++;
    e_req = !fl && !st[0] && (inflight.size() < MAXO) && ((pf.size() + live) < DEPTH);
    chk("ibus_req", ibus_req_o, e_req);
    chk("ibus_addr", ibus_addr_o, m_pc);
    chk("inst_valid", inst_valid_o, pf.size() > 0);
    chk("inst_addr", inst_addr_o, (pf.size() > 0) ? pf[0].addr : 32'h0);
    chk("inst", inst_o, (pf.size() > 0) ? pf[0].inst : INST_NOP);

    if (ibus_req_o && ibus_gnt_i) begin
      issued.push_back(ibus_addr_o);
      bus_q.push_back(ibus_addr_o);
    end
    if (inst_valid_o && !st[1] && !fl) delivered.push_back(inst_addr_o);

    acc   = e_req && ibus_gnt_i;
    pop   = (pf.size() > 0) && !st[1] && !fl;
    got_r = 1'b0;
    if (rv) begin
      void'(bus_q.pop_front());
      if (inflight.size() > 0) begin
        r     = inflight.pop_front();
        got_r = 1'b1;
      end
    end
    if (fl) begin
      pf.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      m_pc = ja & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(pf.pop_front());
      if (got_r && !r.stale) pf.push_back('{r.addr, rd});
      if (acc) begin
        inflight.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Reset asserted between clock edges; outputs must react without a clock edge.
  task automatic async_reset();
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_req", ibus_req_o, 1'b0);
    chk("rst_valid", inst_valid_o, 1'b0);
    chk("rst_inst", inst_o, INST_NOP);
    chk("rst_inst_addr", inst_addr_o, 32'h0);
    chk("rst_pc", ibus_addr_o, RST_PC);
    stall_i       = '0;
    flush_jump_i  = 1'b0;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  function automatic int pick_pct();
    case ($urandom_range(3))
      0:       return 0;
      1:       return 30;
      2:       return 70;
      default: return 100;
    endcase
  endfunction

  initial begin
    rst_n_i       = 1'b0;
    stall_i       = '0;
    flush_jump_i  = 1'b0;
    jump_addr_i   = '0;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = '0;
    model_reset();

    // In-order fetch and delivery from reset.
    async_reset();
    clear_logs();
    repeat (10) step(6'b0, 1'b0, 32'h0, 100, 100);
    chk("t1_iss0", at(issued, 0), 32'h0);
    chk("t1_iss1", at(issued, 1), 32'h4);
    chk("t1_iss2", at(issued, 2), 32'h8);
    chk("t1_del0", at(delivered, 0), 32'h0);
    chk("t1_del1", at(delivered, 1), 32'h4);
    chk("t1_del2", at(delivered, 2), 32'h8);

    // Decode stall holds the head, buffer fills, issue stops.
    async_reset();
    clear_logs();
    repeat (5) step(6'b000010, 1'b0, 32'h0, 100, 100);
    chk("t2_req_held", ibus_req_o, 1'b0);
    chk("t2_head_valid", inst_valid_o, 1'b1);
    chk("t2_head_addr", inst_addr_o, 32'h0);
    chk("t2_head_inst", inst_o, 32'h0000_0013);
    repeat (12) step(6'b0, 1'b0, 32'h0, 100, 100);
    chk("t2_del0", at(delivered, 0), 32'h0);
    chk("t2_del1", at(delivered, 1), 32'h4);
    chk("t2_del2", at(delivered, 2), 32'h8);

    // Redirect with two requests in flight: both responses are dropped.
    async_reset();
    step(6'b0, 1'b1, 32'h10, 0, 0);
    repeat (3) step(6'b0, 1'b0, 32'h0, 100, 0);
    chk("t3_req_limit", ibus_req_o, 1'b0);
    clear_logs();
    step(6'b0, 1'b1, 32'h200, 100, 0);
    repeat (12) step(6'b0, 1'b0, 32'h0, 100, 100);
    chk("t3_iss0", at(issued, 0), 32'h200);
    chk("t3_del0", at(delivered, 0), 32'h200);
    chk("t3_del1", at(delivered, 1), 32'h204);

    // Redirect in the same cycle as a response, one more still in flight.
    async_reset();
    step(6'b0, 1'b1, 32'h10, 0, 0);
    repeat (3) step(6'b0, 1'b0, 32'h0, 100, 0);
    clear_logs();
    step(6'b0, 1'b1, 32'h200, 100, 100);
    repeat (12) step(6'b0, 1'b0, 32'h0, 100, 100);
    chk("t4_iss0", at(issued, 0), 32'h200);
    chk("t4_del0", at(delivered, 0), 32'h200);
    chk("t4_del1", at(delivered, 1), 32'h204);

    // Unaligned target and address wrap at the top of the space.
    async_reset();
    clear_logs();
    step(6'b0, 1'b1, 32'h203, 0, 0);
    repeat (6) step(6'b0, 1'b0, 32'h0, 100, 100);
    chk("t5_align", at(issued, 0), 32'h200);
    clear_logs();
    step(6'b0, 1'b1, 32'hFFFF_FFFC, 0, 0);
    repeat (10) step(6'b0, 1'b0, 32'h0, 100, 100);
    chk("t5_iss0", at(issued, 0), 32'hFFFF_FFFC);
    chk("t5_iss1", at(issued, 1), 32'h0);
    chk("t5_del0", at(delivered, 0), 32'hFFFF_FFFC);
    chk("t5_del1", at(delivered, 1), 32'h0);

    // Reset in the middle of a burst with the buffer full.
    async_reset();
    repeat (5) step(6'b000010, 1'b0, 32'h0, 100, 100);
    chk("t6_full_valid", inst_valid_o, 1'b1);
    async_reset();
    clear_logs();
    repeat (4) step(6'b0, 1'b0, 32'h0, 100, 100);
    chk("t6_iss0", at(issued, 0), RST_PC);

    // Randomised traffic against the model.
    for (int seg = 0; seg < 60; seg++) begin
      int pg;
      int pr;
      pg = pick_pct();
      pr = pick_pct();
      if (seg == 30) async_reset();
      for (int c = 0; c < 50; c++) begin
        logic [5:0] st;
        st    = 6'($urandom);
        st[0] = ($urandom_range(99) < 15);
        st[1] = ($urandom_range(99) < 25);
        step(st, ($urandom_range(99) < 4), $urandom, pg, pr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
